apb_slave_mem: RTL

- APB completer: the responder end of the 8-bit-data APB bus driven by the team's APB master bridge.
- Instantiated once per slave select (PSEL1 / PSEL2). Sees only the local 8-bit address (master PADDR[7:0]); master PADDR[8] has already done slave selection.
- Holds a byte-wide register file. Inserts a programmable number of wait states via PREADY. Optionally flags errors on PSLVERR.

---
 rtl/apb_slave_pkg.sv | 26 ++
 rtl/apb_slave_regfile.sv | 57 +++++
 rtl/apb_slave_mem.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/apb_slave_pkg.sv
// ----------------------------------------------------------------------------
// apb_slave_pkg
// Shared definitions for the APB completer memory (apb_slave_mem):
//   - state_t     : transfer FSM states (IDLE, ACCESS)
//   - DEF_*       : default parameter values
//   - cnt_width() : wait-counter width, clog2(WAIT_CYCLES + 1), minimum 1
// ----------------------------------------------------------------------------
package apb_slave_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int DEF_ADDR_WIDTH  = 8;
    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_DEPTH       = 256;
    localparam int DEF_WAIT_CYCLES = 2;

    function automatic int cnt_width(input int wait_cycles);
        int w;
        w = $clog2(wait_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// ----------------------------------------------------------------------------
// apb_slave_regfile
// DEPTH x DATA_WIDTH register file with synchronous write, registered read
// and a synchronous clear of every location on srst_i.
// Addresses >= DEPTH are guarded: writes are dropped, reads return 0.
// Ports:
//   clk_i, srst_i       clock / synchronous active-high reset
//   we_i, waddr_i,
//   wdata_i             write port (applied at the clock edge)
//   re_i, raddr_i       read strobe / address
//   rdata_o             registered read data, holds until the next re_i
// ----------------------------------------------------------------------------
module apb_slave_regfile #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  wr_ok;
    logic                  rd_ok;

    // Extra MSB keeps the compare correct when DEPTH == 2**ADDR_WIDTH.
    assign wr_ok = ({1'b0, waddr_i} < DEPTH_LIM);
    assign rd_ok = ({1'b0, raddr_i} < DEPTH_LIM);

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (we_i && wr_ok) begin
                mem_q[waddr_i[IDX_W-1:0]] <= wdata_i;
            end
            if (re_i) begin
                rdata_q <= rd_ok ? mem_q[raddr_i[IDX_W-1:0]] : '0;
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/apb_slave_mem.sv
// ----------------------------------------------------------------------------
// apb_slave_mem
// APB completer with a byte-wide register file and WAIT_CYCLES wait states
// per access phase. Transfer: setup cycle, then WAIT_CYCLES + 1 access cycles,
// PREADY high only in the last one.
// Optional error reporting on PSLVERR is built when APB_SLAVE_ERR_EN is
// defined; otherwise PSLVERR is tied to 0.
// Ports:
//   PCLK, PRESET        clock / synchronous active-high reset
//   PSEL, PENABLE,
//   PWRITE, PADDR,
//   PWDATA              APB requester signals
//   PRDATA              read data (holds last read value)
//   PREADY              high in the completion cycle only
//   PSLVERR             error response, valid with PREADY
// ----------------------------------------------------------------------------
module apb_slave_mem
    import apb_slave_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);
    localparam int             CW        = cnt_width(WAIT_CYCLES);
    localparam logic [CW-1:0]  WAIT_LOAD = CW'(WAIT_CYCLES);

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   write_q, write_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;

    logic                   setup;
    logic                   access_cyc;
    logic                   complete;
    logic                   err_now;
    logic [DATA_WIDTH-1:0]  rd_data;

    assign setup      = (state_q == IDLE) && PSEL && !PENABLE;
    assign access_cyc = (state_q == ACCESS) && PSEL && PENABLE;
    assign complete   = access_cyc && (cnt_q == '0);

    // A completed transfer always returns to IDLE; a back-to-back setup in
    // the following cycle is then captured from IDLE, which is equivalent
    // to staying in ACCESS.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (setup) begin
                    state_d = ACCESS;
                    cnt_d   = WAIT_LOAD;
                    addr_d  = PADDR;
                    write_d = PWRITE;
                    wdata_d = PWDATA;
                end
            end
            ACCESS: begin
                if (complete || !access_cyc) begin
                    state_d = IDLE;  // completion or abort
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
        end
    end

    // Read is issued at the setup edge so data is ready in the first
    // access cycle; write lands at the closing edge of the completion cycle.
    apb_slave_regfile #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_regfile (
        .clk_i   (PCLK),
        .srst_i  (PRESET),
        .we_i    (complete && write_q && !err_now),
        .waddr_i (addr_q),
        .wdata_i (wdata_q),
        .re_i    (setup && !PWRITE),
        .raddr_i (PADDR),
        .rdata_o (rd_data)
    );

    assign PREADY = complete;

`ifdef APB_SLAVE_ERR_EN
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    logic err_q, err_d;     // setup/access mismatch seen in this transfer
    logic pend_q, pend_d;   // PENABLE without setup seen while idle
    logic mismatch;
    logic addr_oor;

    assign mismatch = (PADDR != addr_q) || (PWRITE != write_q) ||
                      (write_q && (PWDATA != wdata_q));
    assign addr_oor = ({1'b0, addr_q} >= DEPTH_LIM);
    assign err_now  = complete && (addr_oor || err_q || pend_q || mismatch);

    always_comb begin
        err_d  = err_q;
        pend_d = pend_q;
        if (setup) begin
            err_d = 1'b0;
        end else if (access_cyc && mismatch) begin
            err_d = 1'b1;
        end
        if (complete) begin
            pend_d = 1'b0;
        end else if ((state_q == IDLE) && PSEL && PENABLE) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            err_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            err_q  <= err_d;
            pend_q <= pend_d;
        end
    end

    assign PSLVERR = err_now;
    assign PRDATA  = (err_now && !write_q) ? '0 : rd_data;
`else
    assign err_now = 1'b0;
    assign PSLVERR = 1'b0;
    assign PRDATA  = rd_data;
`endif

endmodule
